// File: rtl/load_unit.sv
// load_unit: load path of the MEM stage.
// Takes a load from EX/MEM, issues it on the sram-like data port, extracts and
// extends the selected byte/halfword/word, and holds the result for WB.
// A flush cancels an in-flight load without breaking the req/addr_ok/data_ok
// protocol: an issued request is always followed through to its data_ok.
// Optional feature: define UNALIGNED_LOAD_EN to support LWL/LWR
// (little-endian merge with rt_old, no alignment check).
`timescale 1ns/1ps
module load_unit #(
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [DEST_W-1:0] req_dest,
  input  logic [31:0]       req_rt_old,
  output logic              sram_req,
  output logic [31:0]       sram_addr,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [31:0]       sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              adel,
  output logic              busy
);

  localparam logic [2:0] T_LW  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LB  = 3'b010;
  localparam logic [2:0] T_LHU = 3'b101;
  localparam logic [2:0] T_LBU = 3'b110;
`ifdef UNALIGNED_LOAD_EN
  localparam logic [2:0] T_LWL = 3'b011;
  localparam logic [2:0] T_LWR = 3'b111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  logic [2:0]        r_type;
  logic [1:0]        r_off;
  logic [DEST_W-1:0] r_dest;
  logic              r_cancel;

  logic              w_accept;
  logic              w_misaligned;
  logic [4:0]        w_shamt;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_result;

`ifdef UNALIGNED_LOAD_EN
  logic [31:0]       r_rt_old;
  logic [31:0]       w_lwl;
  logic [31:0]       w_lwr;
`else
  // rt_old only matters for LWL/LWR, which this build treats as LW.
  logic              w_unused;
  assign w_unused = ^req_rt_old;
`endif

  assign req_ready = (r_state == S_IDLE) && !flush;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;

  // Alignment check on the incoming request; unknown codes are checked as LW.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_type)
      T_LH, T_LHU: w_misaligned = req_addr[0];
      T_LB, T_LBU: w_misaligned = 1'b0;
`ifdef UNALIGNED_LOAD_EN
      T_LWL, T_LWR: w_misaligned = 1'b0;
`endif
      default:     w_misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign w_shamt = {r_off, 3'b000};
  assign w_byte  = 8'(sram_rdata >> w_shamt);
  assign w_half  = r_off[1] ? sram_rdata[31:16] : sram_rdata[15:0];

`ifdef UNALIGNED_LOAD_EN
  // LWL places the low (a+1) bytes of the word at the top of rt; LWR places
  // the high (4-a) bytes at the bottom. The rest of rt is preserved.
  assign w_lwl = (sram_rdata << (5'd24 - w_shamt)) | (r_rt_old & (32'h00FF_FFFF >> w_shamt));
  assign w_lwr = (sram_rdata >> w_shamt) | (r_rt_old & ~(32'hFFFF_FFFF >> w_shamt));
`endif

  // Select and extend the loaded field from the returned word.
  always_comb begin
    w_result = sram_rdata;
    case (r_type)
      T_LB:    w_result = {{24{w_byte[7]}}, w_byte};
      T_LBU:   w_result = {24'h0, w_byte};
      T_LH:    w_result = {{16{w_half[15]}}, w_half};
      T_LHU:   w_result = {16'h0, w_half};
`ifdef UNALIGNED_LOAD_EN
      T_LWL:   w_result = w_lwl;
      T_LWR:   w_result = w_lwr;
`endif
      default: w_result = sram_rdata;
    endcase
  end

  // Control FSM with registered port outputs and the cancel flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_type    <= T_LW;
      r_off     <= 2'b00;
      r_dest    <= '0;
      r_cancel  <= 1'b0;
      sram_req  <= 1'b0;
      sram_addr <= 32'h0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_dest  <= '0;
      adel      <= 1'b0;
`ifdef UNALIGNED_LOAD_EN
      r_rt_old  <= 32'h0;
`endif
    end else begin
      adel <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cancel <= 1'b0;
          if (w_accept) begin
            if (w_misaligned) begin
              adel <= 1'b1;
            end else begin
              r_type    <= req_type;
              r_off     <= req_addr[1:0];
              r_dest    <= req_dest;
`ifdef UNALIGNED_LOAD_EN
              r_rt_old  <= req_rt_old;
`endif
              sram_req  <= 1'b1;
              sram_addr <= {req_addr[31:2], 2'b00};
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // The request cannot be withdrawn; a flush only marks it cancelled.
          if (flush) r_cancel <= 1'b1;
          if (sram_addr_ok) begin
            sram_req <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) r_cancel <= 1'b1;
          if (sram_data_ok) begin
            r_cancel <= 1'b0;
            if (r_cancel || flush) begin
              r_state <= S_IDLE;
            end else begin
              out_data  <= w_result;
              out_dest  <= r_dest;
              out_valid <= 1'b1;
              r_state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // out_ready together with flush counts as delivered either way.
          if (out_ready || flush) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: scoreboard bench for load_unit. Expected results are queued when
// a load is driven and compared when out_valid appears. Memory port responses
// are driven directly by the transaction task with programmable waits.
`timescale 1ns/1ps
module tb_load_unit;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_type;
  logic [31:0]       req_addr;
  logic [DEST_W-1:0] req_dest;
  logic [31:0]       req_rt_old;
  logic              sram_req;
  logic [31:0]       sram_addr;
  logic              sram_addr_ok;
  logic              sram_data_ok;
  logic [31:0]       sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [DEST_W-1:0] out_dest;
  logic              adel;
  logic              busy;

  typedef struct packed {
    logic [31:0]       data;
    logic [DEST_W-1:0] dest;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  load_unit #(.DEST_W(DEST_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_dest(req_dest), .req_rt_old(req_rt_old),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .adel(adel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference extraction written byte-by-byte from the load definitions.
  function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (t)
      3'b010:  return {{24{b[7]}}, b};
      3'b110:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // One complete load: accept, REQ with aw wait cycles, WAIT with dw wait
  // cycles, then HOLD for hold cycles before out_ready.
  task automatic run_load(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] rt_old, input logic [DEST_W-1:0] dest,
                          input logic [31:0] exp_data, input int aw, input int dw, input int hold);
    exp_t e;
    exp_t got;
    int   cyc;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_type   = t;
    req_addr   = addr;
    req_rt_old = rt_old;
    req_dest   = dest;
    e.data = exp_data;
    e.dest = dest;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_rt_old = $urandom;
    req_dest   = DEST_W'($urandom);
    check_eq("sram_req_on", sram_req, 1);
    check_eq("sram_addr", sram_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < aw; i++) begin
      @(negedge clk);
      check_eq("sram_req_held", sram_req, 1);
    end
    sram_addr_ok = 1'b1;
    @(negedge clk);
    sram_addr_ok = 1'b0;
    check_eq("sram_req_off", sram_req, 0);
    for (int i = 0; i < dw; i++) @(negedge clk);
    sram_data_ok = 1'b1;
    sram_rdata   = rdata;
    @(negedge clk);
    sram_data_ok = 1'b0;
    sram_rdata   = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("out_valid_latency", cyc, 0);
    check_eq("out_valid", out_valid, 1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_eq("out_data", out_data, got.data);
      check_eq("out_dest", out_dest, got.dest);
      $display("load type=%03b addr=0x%08h rdata=0x%08h -> out_data=0x%08h exp=0x%08h", t, addr, rdata, out_data, got.data);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_data", out_data, e.data);
      check_eq("hold_dest", out_dest, e.dest);
      check_eq("hold_ready", req_ready, 0);
      check_eq("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("after_out_valid", out_valid, 0);
    check_eq("after_busy", busy, 0);
    check_eq("after_ready", req_ready, 1);
  endtask

  // Misaligned request: one-cycle adel, no memory request.
  task automatic run_adel(input logic [2:0] t, input logic [31:0] addr);
    @(negedge clk);
    check_eq("adel_ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("adel_pulse", adel, 1);
    check_eq("adel_no_req", sram_req, 0);
    check_eq("adel_ready", req_ready, 1);
    check_eq("adel_busy", busy, 0);
    @(negedge clk);
    check_eq("adel_one_cycle", adel, 0);
    check_eq("adel_no_req_later", sram_req, 0);
    $display("adel type=%03b addr=0x%08h", t, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_type = 3'b000;
    req_addr = 32'h0; req_dest = '0; req_rt_old = 32'h0;
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sram_req", sram_req, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_adel", adel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_dest", out_dest, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);

    run_load(3'b010, 32'h0000_1003, 32'h80FF_1234, 32'h0, 5'd3,  32'hFFFF_FF80, 0, 0, 0);
    run_load(3'b110, 32'h0000_1003, 32'h80FF_1234, 32'h0, 5'd4,  32'h0000_0080, 0, 0, 0);
    run_load(3'b001, 32'h0000_1002, 32'h8001_7FFF, 32'h0, 5'd5,  32'hFFFF_8001, 0, 0, 0);
    run_load(3'b101, 32'h0000_1000, 32'h8001_7FFF, 32'h0, 5'd6,  32'h0000_7FFF, 0, 0, 0);
    run_load(3'b000, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 5'd31, 32'hDEAD_BEEF, 2, 1, 4);

    for (int o = 0; o < 4; o++) begin
      logic [31:0] d;
      logic [1:0]  oa;
      d  = $urandom;
      oa = 2'(o);
      run_load(3'b010, 32'h0000_2000 + 32'(o), d, 32'h0, 5'(o + 8),  ref_ext(3'b010, oa, d), o, 3 - o, 1);
      run_load(3'b110, 32'h0000_2000 + 32'(o), d, 32'h0, 5'(o + 12), ref_ext(3'b110, oa, d), 0, o, 0);
    end
    for (int o = 0; o < 4; o += 2) begin
      logic [31:0] d;
      logic [1:0]  oa;
      d  = $urandom;
      oa = 2'(o);
      run_load(3'b001, 32'h0000_3000 + 32'(o), d, 32'h0, 5'(o + 16), ref_ext(3'b001, oa, d), 1, 0, 0);
      run_load(3'b101, 32'h0000_3000 + 32'(o), d, 32'h0, 5'(o + 20), ref_ext(3'b101, oa, d), 0, 1, 0);
    end

    run_adel(3'b000, 32'h0000_1006);
    run_adel(3'b001, 32'h0000_1001);
    run_adel(3'b101, 32'h0000_1003);

    // Flush in the first REQ cycle with addr_ok delayed 3 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'b000; req_addr = 32'h0000_4000; req_dest = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("flush_req_on", sram_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_req_held1", sram_req, 1);
    @(negedge clk);
    check_eq("flush_req_held2", sram_req, 1);
    sram_addr_ok = 1'b1;
    @(negedge clk);
    sram_addr_ok = 1'b0;
    check_eq("flush_req_off", sram_req, 0);
    check_eq("flush_wait_busy", busy, 1);
    sram_data_ok = 1'b1; sram_rdata = 32'h1234_5678;
    @(negedge clk);
    sram_data_ok = 1'b0;
    check_eq("flush_idle_busy", busy, 0);
    check_eq("flush_idle_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_no_valid", out_valid, 0);
      @(negedge clk);
    end
    $display("flush during REQ: request completed and discarded");

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_5000;
    #1;
    check_eq("flush_idle_block", req_ready, 0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check_eq("flush_idle_noreq", sram_req, 0);
    check_eq("flush_idle_nobusy", busy, 0);
    $display("flush in IDLE: request blocked");

    // Flush in HOLD drops out_valid.
    run_load(3'b000, 32'h0000_6000, 32'hCAFE_F00D, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'b000; req_addr = 32'h0000_6004; req_dest = 5'd10;
    @(negedge clk);
    req_valid = 1'b0; sram_addr_ok = 1'b1;
    @(negedge clk);
    sram_addr_ok = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    sram_data_ok = 1'b0;
    check_eq("hflush_valid", out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("hflush_dropped", out_valid, 0);
    check_eq("hflush_idle", busy, 0);
    $display("flush in HOLD: result dropped");

`ifdef UNALIGNED_LOAD_EN
    run_load(3'b011, 32'h0000_7001, 32'hAABB_CCDD, 32'h1122_3344, 5'd1, 32'hCCDD_3344, 0, 0, 0);
    run_load(3'b111, 32'h0000_7001, 32'hAABB_CCDD, 32'h1122_3344, 5'd2, 32'h11AA_BBCC, 1, 1, 0);
    run_load(3'b011, 32'h0000_7003, 32'hAABB_CCDD, 32'h1122_3344, 5'd3, 32'hAABB_CCDD, 0, 0, 0);
    run_load(3'b111, 32'h0000_7000, 32'hAABB_CCDD, 32'h1122_3344, 5'd4, 32'hAABB_CCDD, 0, 0, 0);
    run_load(3'b011, 32'h0000_7000, 32'hAABB_CCDD, 32'h1122_3344, 5'd5, 32'hDD22_3344, 0, 0, 0);
    run_load(3'b111, 32'h0000_7003, 32'hAABB_CCDD, 32'h1122_3344, 5'd6, 32'h1122_33AA, 0, 0, 0);
`else
    run_adel(3'b011, 32'h0000_7001);
    run_adel(3'b111, 32'h0000_7002);
    run_load(3'b011, 32'h0000_7000, 32'hAABB_CCDD, 32'h1122_3344, 5'd1, 32'hAABB_CCDD, 0, 0, 0);
    run_load(3'b111, 32'h0000_7004, 32'h5566_7788, 32'h1122_3344, 5'd2, 32'h5566_7788, 0, 0, 0);
`endif

    // Asynchronous reset in the middle of a transaction.
    @(negedge clk);
    req_valid = 1'b1; req_type = 3'b000; req_addr = 32'h0000_8000; req_dest = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("arst_busy_before", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_sram_req", sram_req, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("arst_ready", req_ready, 1);
    $display("async reset mid-transaction: back to IDLE");

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
